lsu_bus_if: RTL

- Load/store unit directly downstream of the instruction decoder; consumes its mem_we/mem_ctrl outputs plus the ALU address and rs2 data.
- Converts each load/store into word-aligned bus transactions with byte enables, a valid/ready handshake, lane steering and load sign/zero extension.
- Stalls the core until the access completes.

---
 rtl/lsu_bus_if.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_if.sv
// Load/store bus adapter: word-aligned valid/ready accesses, byte enables, lane steering, load extension; holds stall until done.
// Latency 3 cycles aligned (4 when split); `LSU_MISALIGN_SPLIT_EN legalises unaligned accesses and splits word-crossing ones.
module lsu_bus_if #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              mem_we,
  input  logic [2:0]        mem_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic                r_bus_we;
  logic [3:0]          r_bus_be;
  logic [31:0]         r_bus_wdata;
  logic [31:0]         r_rdata;
  logic                r_misalign;
  logic [1:0]          r_off;
  logic [2:0]          r_ctrl;

  logic [1:0]          w_off;
  logic [3:0]          w_base;
  logic [3:0]          w_be_lo;
  logic [31:0]         w_wdata_lo;
  logic                w_legal;
  logic                w_fin;
  logic [31:0]         w_merged;
  logic [31:0]         w_ext;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic                r_split;
  logic [3:0]          r_be_hi;
  logic [31:0]         r_wdata_hi;
  logic [31:0]         r_low;
  logic [7:0]          w_mask8;
  logic [3:0]          w_be_hi;
  logic [31:0]         w_wdata_hi;
  logic [63:0]         w_wide;
  logic [63:0]         w_cat;
`endif

  assign w_off = addr[1:0];

  always_comb begin
    w_base = 4'b1111;
    case (mem_ctrl[1:0])
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Bytes shifted past lane 3 become the second (next-word) access.
  assign w_mask8    = {4'b0000, w_base} << w_off;
  assign w_be_lo    = w_mask8[3:0];
  assign w_be_hi    = w_mask8[7:4];
  assign w_wide     = {32'h0, wdata} << {w_off, 3'b000};
  assign w_wdata_lo = w_wide[31:0];
  assign w_wdata_hi = w_wide[63:32];
  assign w_legal    = 1'b1;
  assign w_fin      = bus_ready & (((r_state == S_ACC0) & ~r_split) | (r_state == S_ACC1));
  assign w_cat      = (r_state == S_ACC1) ? {bus_rdata, r_low} : {32'h0, bus_rdata};
  assign w_merged   = 32'(w_cat >> {r_off, 3'b000});
`else
  assign w_be_lo    = w_base << w_off;
  assign w_wdata_lo = wdata << {w_off, 3'b000};
  assign w_fin      = bus_ready & (r_state == S_ACC0);
  assign w_merged   = bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_legal = 1'b1;
    case (mem_ctrl[1:0])
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~addr[0];
      default: w_legal = (w_off == 2'b00);
    endcase
  end
`endif

  always_comb begin
    w_ext = w_merged;
    case (r_ctrl[1:0])
      2'b00:   w_ext = r_ctrl[2] ? {24'h0, w_merged[7:0]}
                                 : {{24{w_merged[7]}}, w_merged[7:0]};
      2'b01:   w_ext = r_ctrl[2] ? {16'h0, w_merged[15:0]}
                                 : {{16{w_merged[15]}}, w_merged[15:0]};
      default: w_ext = w_merged;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req) w_next = w_legal ? S_ACC0 : S_DONE;
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACC0: if (bus_ready) w_next = r_split ? S_ACC1 : S_DONE;
      S_ACC1: if (bus_ready) w_next = S_DONE;
`else
      S_ACC0: if (bus_ready) w_next = S_DONE;
      S_ACC1: w_next = S_IDLE;
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_rdata     <= 32'h0;
      r_misalign  <= 1'b0;
      r_off       <= 2'b00;
      r_ctrl      <= 3'b000;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split     <= 1'b0;
      r_be_hi     <= 4'b0000;
      r_wdata_hi  <= 32'h0;
      r_low       <= 32'h0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req) begin
        if (w_legal) begin
          r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
          r_bus_we    <= mem_we;
          r_bus_be    <= w_be_lo;
          r_bus_wdata <= w_wdata_lo;
          r_off       <= w_off;
          r_ctrl      <= mem_ctrl;
`ifdef LSU_MISALIGN_SPLIT_EN
          r_split     <= |w_be_hi;
          r_be_hi     <= w_be_hi;
          r_wdata_hi  <= w_wdata_hi;
`endif
        end else begin
          r_misalign <= 1'b1;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (r_state == S_ACC0 && bus_ready && r_split) begin
        r_low       <= bus_rdata;
        r_bus_addr  <= r_bus_addr + ADDR_W'(4);
        r_bus_be    <= r_be_hi;
        r_bus_wdata <= r_wdata_hi;
      end
`endif
      // rdata only moves on a completed load; stores and faults leave it.
      if (w_fin) begin
        r_misalign <= 1'b0;
        if (!r_bus_we) r_rdata <= w_ext;
      end
    end
  end

  assign stall     = req & (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign bus_valid = (r_state == S_ACC0) | (r_state == S_ACC1);
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign rdata     = r_rdata;
  assign misalign  = r_misalign;

endmodule
